// File: rtl/eth_rx_pkg.sv
// Shared definitions for the GMII receive path.
// Holds the framer FSM encoding, the preamble/SFD byte values, the CRC-32 constants
// used by the optional FCS check (GMII_RX_FCS_CHECK_EN), the frame length width, and
// a saturating increment helper for the drop counter.

package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        BODY     = 2'd2,
        DROP     = 2'd3
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Reflected CRC-32; running the register over body plus FCS leaves the residue.
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned LEN_W = 16;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected, polynomial 0xEDB88320) next-state for one data byte.
// Ports:
//   data    - byte to fold in, bit 0 first
//   crc_in  - current CRC register
//   crc_out - CRC register after the byte

module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: finds preamble + SFD, strips them and the 4-byte FCS, and
// streams the frame body on rx_en/rx_data (byte 0 = first destination-MAC byte).
// Each frame ends with a one-cycle frame_done carrying frame_good and frame_len;
// bad or aborted frames bump a saturating drop_count.
// Optional feature: define GMII_RX_FCS_CHECK_EN to build a CRC-32 check whose failure
// forces frame_good low. Without it the CRC term always passes; timing is unchanged.
// Ports:
//   clk, rst                          - 125 MHz receive clock, async active-high reset
//   gmii_rx_dv, gmii_rx_er, gmii_rxd  - GMII receive pins (registered once internally)
//   rx_en, rx_data                    - body byte stream, contiguous per frame
//   frame_done, frame_good, frame_len - end-of-frame summary pulse
//   drop_count                        - saturating count of bad/aborted frames
//   state                             - FSM state for debug

module gmii_rx_framer
    import eth_rx_pkg::*;
#(
    parameter int unsigned MIN_PREAMBLE = 1,
    parameter int unsigned MIN_LEN      = 60,
    parameter int unsigned MAX_FRAME    = 1518
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    output logic             rx_en,
    output logic [7:0]       rx_data,
    output logic             frame_done,
    output logic             frame_good,
    output logic [LEN_W-1:0] frame_len,
    output logic [31:0]      drop_count,
    output logic [1:0]       state
);

    logic             in_dv_q;
    logic             in_er_q;
    logic [7:0]       in_d_q;

    rx_state_e        st_q;
    logic [2:0]       pcnt_q;
    // Four-byte FCS delay line: newest byte in [7:0], oldest in [31:24].
    logic [31:0]      dly_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [LEN_W-1:0] emit_cnt_q;
    logic             err_seen_q;
    logic             crc_ok;
    logic             body_good;

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0]      crc_q;
    logic [31:0]      crc_next;

    crc32_d8 u_crc (
        .data    (in_d_q),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    // By the time dv=0 is seen the register has absorbed every body byte incl. FCS.
    assign crc_ok = (crc_q == CRC32_RESIDUE);
`else
    assign crc_ok = 1'b1;
`endif

    assign body_good = (emit_cnt_q >= LEN_W'(MIN_LEN)) && !err_seen_q && crc_ok;
    assign state     = st_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_dv_q    <= 1'b0;
            in_er_q    <= 1'b0;
            in_d_q     <= 8'h00;
            st_q       <= IDLE;
            pcnt_q     <= 3'd0;
            dly_q      <= 32'h0;
            byte_cnt_q <= '0;
            emit_cnt_q <= '0;
            err_seen_q <= 1'b0;
            rx_en      <= 1'b0;
            rx_data    <= 8'h00;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_len  <= '0;
            drop_count <= 32'h0;
`ifdef GMII_RX_FCS_CHECK_EN
            crc_q      <= CRC32_INIT;
`endif
        end else begin
            in_dv_q    <= gmii_rx_dv;
            in_er_q    <= gmii_rx_er;
            in_d_q     <= gmii_rxd;
            rx_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;

            unique case (st_q)
                IDLE: begin
                    if (in_dv_q) begin
                        if (in_d_q == PREAMBLE_BYTE) begin
                            st_q   <= PREAMBLE;
                            pcnt_q <= 3'd1;
                        end else begin
                            // Joined mid-frame or garbage: ignore without counting.
                            st_q <= DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!in_dv_q) begin
                        st_q       <= IDLE;
                        drop_count <= sat_inc32(drop_count);
                    end else if (in_d_q == PREAMBLE_BYTE) begin
                        if (pcnt_q != 3'd7) begin
                            pcnt_q <= pcnt_q + 3'd1;
                        end
                    end else if (in_d_q == SFD_BYTE && pcnt_q >= 3'(MIN_PREAMBLE)) begin
                        st_q       <= BODY;
                        dly_q      <= 32'h0;
                        byte_cnt_q <= '0;
                        emit_cnt_q <= '0;
                        err_seen_q <= 1'b0;
`ifdef GMII_RX_FCS_CHECK_EN
                        crc_q      <= CRC32_INIT;
`endif
                    end else begin
                        st_q       <= DROP;
                        drop_count <= sat_inc32(drop_count);
                    end
                end

                BODY: begin
                    if (!in_dv_q) begin
                        frame_done <= 1'b1;
                        frame_good <= body_good;
                        frame_len  <= emit_cnt_q;
                        st_q       <= IDLE;
                        if (!body_good) begin
                            drop_count <= sat_inc32(drop_count);
                        end
                    end else if (byte_cnt_q == LEN_W'(MAX_FRAME)) begin
                        // Byte MAX_FRAME+1 arrived: abort, output stops this cycle.
                        frame_done <= 1'b1;
                        frame_good <= 1'b0;
                        frame_len  <= emit_cnt_q;
                        st_q       <= DROP;
                        drop_count <= sat_inc32(drop_count);
                    end else begin
                        dly_q      <= {dly_q[23:0], in_d_q};
                        byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                        err_seen_q <= err_seen_q | in_er_q;
`ifdef GMII_RX_FCS_CHECK_EN
                        crc_q      <= crc_next;
`endif
                        // Emit the byte received four bytes ago; the last four never leave.
                        if (byte_cnt_q >= LEN_W'(4)) begin
                            rx_en      <= 1'b1;
                            rx_data    <= dly_q[31:24];
                            emit_cnt_q <= emit_cnt_q + LEN_W'(1);
                        end
                    end
                end

                DROP: begin
                    if (!in_dv_q) begin
                        st_q <= IDLE;
                    end
                end

                default: st_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_framer.sv
module tb_gmii_rx_framer;

    localparam int MIN_LEN   = 60;
    localparam int MAX_FRAME = 1518;

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic        frame_done;
    logic        frame_good;
    logic [15:0] frame_len;
    logic [31:0] drop_count;
    logic [1:0]  state;

    gmii_rx_framer #(
        .MIN_PREAMBLE (1),
        .MIN_LEN      (MIN_LEN),
        .MAX_FRAME    (MAX_FRAME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_rxd   (gmii_rxd),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .frame_done (frame_done),
        .frame_good (frame_good),
        .frame_len  (frame_len),
        .drop_count (drop_count),
        .state      (state)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Observed output streams.
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         done_len[$];
    bit         done_good[$];
    int         done_cyc[$];

    always @(negedge clk) begin
        if (rx_en === 1'b1) begin
            got_q.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) begin
            done_len.push_back(int'(frame_len));
            done_good.push_back(frame_good);
            done_cyc.push_back(cyc);
        end
    end

    // Reference model state.
    logic [7:0]  body_q[$];
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    bit          exp_good_q[$];
    int unsigned model_drop = 0;
    int          b4_cyc = 0;

    task automatic clear_all();
        got_q.delete(); got_cyc.delete();
        done_len.delete(); done_good.delete(); done_cyc.delete();
        exp_q.delete(); exp_len_q.delete(); exp_good_q.delete();
    endtask

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, body_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Random payload followed by its FCS (complemented CRC, least significant byte first).
    task automatic make_body(input int n_pay, input bit fcs_good, input bit no55);
        logic [31:0] f;
        body_q.delete();
        for (int i = 0; i < n_pay; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (no55 && b == 8'h55) b = 8'h54;
            body_q.push_back(b);
        end
        f = ~crc_of(n_pay);
        for (int i = 0; i < 4; i++) body_q.push_back(f[8*i +: 8]);
        if (!fcs_good) body_q[n_pay] = body_q[n_pay] ^ 8'h01;
    endtask

    function automatic bit fcs_ok();
`ifdef GMII_RX_FCS_CHECK_EN
        int n;
        logic [31:0] f;
        n = body_q.size();
        if (n < 4) return 1'b0;
        f = ~crc_of(n - 4);
        for (int i = 0; i < 4; i++) if (body_q[n - 4 + i] != f[8*i +: 8]) return 1'b0;
        return 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    // Expected result of one framed body: FCS stripped, truncated when oversize.
    task automatic model(input bit er);
        int  n;
        int  ne;
        bit  over;
        bit  good;
        n    = body_q.size();
        over = (n > MAX_FRAME);
        ne   = over ? MAX_FRAME - 4 : ((n > 4) ? n - 4 : 0);
        for (int i = 0; i < ne; i++) exp_q.push_back(body_q[i]);
        good = !over && (ne >= MIN_LEN) && !er && fcs_ok();
        exp_len_q.push_back(ne);
        exp_good_q.push_back(good);
        if (!good) model_drop++;
    endtask

    task automatic put(input bit dv, input bit er, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic drive_frame(input int npre, input int er_idx, input int gap);
        for (int i = 0; i < npre; i++) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < body_q.size(); i++) begin
            put(1'b1, (i == er_idx), body_q[i]);
            if (i == 4) b4_cyc = cyc;
        end
        idle(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if ({rx_en, frame_done, frame_good} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {rx_en, frame_done, frame_good});
        end
        n_assert++;
        if (rx_data !== 8'h00 || frame_len !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: got data %h len %0d expected 0", rx_data, frame_len);
        end
        n_assert++;
        if (drop_count !== 32'h0 || state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got drops %0d state %0d expected 0", drop_count, state);
        end
        rst = 1'b0;
        model_drop = 0;
        idle(2);
        clear_all();
    endtask

    task automatic test_good_frame();
        int bad;
        clear_all();
        make_body(60, 1'b1, 1'b0);
        model(1'b0);
        drive_frame(7, -1, 1);
        idle(4);
        n_assert++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL good_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_assert++;
        if (bad != 0) begin
            n_fail++; $display("FAIL good_bytes: got %0d wrong bytes expected 0", bad);
        end
        n_assert++;
        if (got_cyc.size() == 0 || got_cyc[0] !== b4_cyc + 2) begin
            n_fail++; $display("FAIL good_latency: got first cycle %0d expected %0d",
                               (got_cyc.size() ? got_cyc[0] : -1), b4_cyc + 2);
        end
        n_assert++;
        if (got_cyc.size() == 0 || got_cyc[$] - got_cyc[0] + 1 !== got_cyc.size()) begin
            n_fail++; $display("FAIL good_contiguous: got span over %0d beats expected contiguous",
                               got_cyc.size());
        end
        n_assert++;
        if (done_len.size() !== 1 || done_len[0] !== exp_len_q[0] || done_good[0] !== exp_good_q[0]) begin
            n_fail++; $display("FAIL good_done: got %0d pulses len %0d good %0d expected 1 len %0d good %0d",
                               done_len.size(), (done_len.size() ? done_len[0] : -1),
                               (done_good.size() ? done_good[0] : 0), exp_len_q[0], exp_good_q[0]);
        end
        n_assert++;
        if (got_cyc.size() == 0 || done_cyc.size() == 0 || done_cyc[0] !== got_cyc[$] + 1) begin
            n_fail++; $display("FAIL good_done_timing: got done cycle %0d expected after last beat",
                               (done_cyc.size() ? done_cyc[0] : -1));
        end
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL good_drops: got %0d expected %0d", drop_count, model_drop);
        end
    endtask

    task automatic test_bad_crc();
        int bad;
        clear_all();
        make_body(60, 1'b1, 1'b0);
        body_q[10] = body_q[10] ^ 8'h20;
        model(1'b0);
        drive_frame(7, -1, 1);
        idle(4);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_assert++;
        if (got_q.size() !== exp_q.size() || bad != 0) begin
            n_fail++; $display("FAIL badcrc_bytes: got %0d beats %0d wrong expected %0d beats 0 wrong",
                               got_q.size(), bad, exp_q.size());
        end
        n_assert++;
        if (done_good.size() !== 1 || done_good[0] !== exp_good_q[0]) begin
            n_fail++; $display("FAIL badcrc_good: got %0d pulses good %0d expected 1 good %0d",
                               done_good.size(), (done_good.size() ? done_good[0] : 0), exp_good_q[0]);
        end
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL badcrc_drops: got %0d expected %0d", drop_count, model_drop);
        end
    endtask

    task automatic test_preamble();
        clear_all();
        // Bad preamble byte: counted abort.
        put(1'b1, 1'b0, 8'h55); put(1'b1, 1'b0, 8'h55); put(1'b1, 1'b0, 8'h44);
        for (int i = 0; i < 20; i++) put(1'b1, 1'b0, 8'($urandom));
        idle(3);
        model_drop++;
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL pre_badbyte_drops: got %0d expected %0d", drop_count, model_drop);
        end
        // dv falls inside the preamble: counted abort.
        put(1'b1, 1'b0, 8'h55); put(1'b1, 1'b0, 8'h55); put(1'b1, 1'b0, 8'h55);
        idle(3);
        model_drop++;
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL pre_dvfall_drops: got %0d expected %0d", drop_count, model_drop);
        end
        // SFD with no preamble starts in IDLE: dropped silently.
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 10; i++) put(1'b1, 1'b0, 8'($urandom));
        idle(3);
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL pre_nosfd_drops: got %0d expected %0d", drop_count, model_drop);
        end
        n_assert++;
        if (got_q.size() !== 0 || done_len.size() !== 0) begin
            n_fail++; $display("FAIL pre_output: got %0d beats %0d done expected 0 0",
                               got_q.size(), done_len.size());
        end
    endtask

    task automatic test_short_and_er();
        int bad;
        clear_all();
        make_body(12, 1'b1, 1'b0);
        model(1'b0);
        drive_frame(1, -1, 1);
        make_body(70, 1'b1, 1'b0);
        model(1'b1);
        drive_frame(3, 30, 1);
        idle(5);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_assert++;
        if (got_q.size() !== exp_q.size() || bad != 0) begin
            n_fail++; $display("FAIL short_er_bytes: got %0d beats %0d wrong expected %0d beats",
                               got_q.size(), bad, exp_q.size());
        end
        n_assert++;
        if (done_len.size() !== 2) begin
            n_fail++; $display("FAIL short_er_done: got %0d pulses expected 2", done_len.size());
        end else begin
            n_assert++;
            if (done_len[0] !== 12 || done_good[0] !== 1'b0) begin
                n_fail++; $display("FAIL short_len: got len %0d good %0d expected len 12 good 0",
                                   done_len[0], done_good[0]);
            end
            n_assert++;
            if (done_len[1] !== exp_len_q[1] || done_good[1] !== exp_good_q[1]) begin
                n_fail++; $display("FAIL er_status: got len %0d good %0d expected len %0d good %0d",
                                   done_len[1], done_good[1], exp_len_q[1], exp_good_q[1]);
            end
        end
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL short_er_drops: got %0d expected %0d", drop_count, model_drop);
        end
    endtask

    task automatic test_oversize();
        int bad;
        int n_first;
        clear_all();
        body_q.delete();
        for (int i = 0; i < 1600; i++) body_q.push_back(8'($urandom));
        model(1'b0);
        n_first = exp_q.size();
        drive_frame(7, -1, 1);
        make_body(64, 1'b1, 1'b0);
        model(1'b0);
        drive_frame(7, -1, 1);
        idle(5);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_assert++;
        if (got_q.size() !== exp_q.size() || bad != 0) begin
            n_fail++; $display("FAIL over_bytes: got %0d beats %0d wrong expected %0d beats",
                               got_q.size(), bad, exp_q.size());
        end
        n_assert++;
        if (done_len.size() !== 2) begin
            n_fail++; $display("FAIL over_done: got %0d pulses expected 2", done_len.size());
        end else begin
            n_assert++;
            if (done_len[0] !== MAX_FRAME - 4 || done_good[0] !== 1'b0) begin
                n_fail++; $display("FAIL over_status: got len %0d good %0d expected len %0d good 0",
                                   done_len[0], done_good[0], MAX_FRAME - 4);
            end
            n_assert++;
            if (got_cyc.size() < n_first || done_cyc[0] !== got_cyc[n_first - 1] + 1) begin
                n_fail++; $display("FAIL over_timing: got done cycle %0d expected one after last beat",
                                   done_cyc[0]);
            end
            n_assert++;
            if (done_len[1] !== exp_len_q[1] || done_good[1] !== exp_good_q[1]) begin
                n_fail++; $display("FAIL over_next_frame: got len %0d good %0d expected len %0d good %0d",
                                   done_len[1], done_good[1], exp_len_q[1], exp_good_q[1]);
            end
        end
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL over_drops: got %0d expected %0d", drop_count, model_drop);
        end
    endtask

    task automatic test_back_to_back_random();
        int bad;
        int nd;
        clear_all();
        for (int f = 0; f < 24; f++) begin
            int  pay;
            bit  er;
            int  er_idx;
            pay = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : $urandom_range(56, 120);
            er  = ($urandom_range(0, 5) == 0);
            make_body(pay, ($urandom_range(0, 3) != 0), 1'b0);
            er_idx = er ? $urandom_range(0, body_q.size() - 1) : -1;
            model(er);
            drive_frame($urandom_range(1, 7), er_idx, $urandom_range(1, 3));
        end
        idle(6);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_assert++;
        if (got_q.size() !== exp_q.size() || bad != 0) begin
            n_fail++; $display("FAIL rand_bytes: got %0d beats %0d wrong expected %0d beats",
                               got_q.size(), bad, exp_q.size());
        end
        nd = 0;
        for (int i = 0; i < exp_len_q.size() && i < done_len.size(); i++)
            if (done_len[i] !== exp_len_q[i] || done_good[i] !== exp_good_q[i]) nd++;
        n_assert++;
        if (done_len.size() !== exp_len_q.size() || nd != 0) begin
            n_fail++; $display("FAIL rand_done: got %0d pulses %0d wrong expected %0d pulses",
                               done_len.size(), nd, exp_len_q.size());
        end
        n_assert++;
        if (drop_count !== model_drop) begin
            n_fail++; $display("FAIL rand_drops: got %0d expected %0d", drop_count, model_drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        make_body(40, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) put(1'b1, 1'b0, body_q[i]);
        #1;
        n_assert++;
        if (rx_en !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_active: got rx_en %b expected 1 before reset", rx_en);
        end
        #1;
        rst = 1'b1;
        #1;
        n_assert++;
        if ({rx_en, frame_done, frame_good} !== 3'b000 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_outputs: got en %b data %h expected 0 0", rx_en, rx_data);
        end
        n_assert++;
        if (drop_count !== 32'h0 || state !== 2'd0 || frame_len !== 16'h0) begin
            n_fail++; $display("FAIL rstmid_state: got drops %0d state %0d len %0d expected 0",
                               drop_count, state, frame_len);
        end
        put(1'b1, 1'b0, body_q[20]);
        put(1'b1, 1'b0, body_q[21]);
        rst = 1'b0;
        clear_all();
        for (int i = 22; i < body_q.size(); i++) put(1'b1, 1'b0, body_q[i]);
        idle(5);
        n_assert++;
        if (got_q.size() !== 0 || done_len.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_ignored: got %0d beats %0d done expected 0 0",
                               got_q.size(), done_len.size());
        end
        n_assert++;
        if (drop_count !== 32'h0 || state !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_after: got drops %0d state %0d expected 0 0",
                               drop_count, state);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_preamble();
        test_short_and_er();
        test_oversize();
        test_back_to_back_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_rx_framer.md
Name: gmii_rx_framer

Overview:
- Receive front end between the GMII receive pins (after the RGMII-to-GMII conversion) and the packet error/sequence checker.
- Detects the preamble and SFD, strips them, and strips the 4-byte FCS.
- Presents the frame body as a contiguous rx_en/rx_data byte stream, so byte index 0 is the first destination-MAC byte.
- Flags each frame good or bad on a one-cycle summary pulse, and counts dropped frames.

Parameters:
- MIN_PREAMBLE, 1: minimum number of 0x55 bytes required before the SFD.
- MIN_LEN, 60: minimum body length in bytes, excluding FCS, for a good frame.
- MAX_FRAME, 1518: maximum body length in bytes, including FCS; above this the frame is aborted.

Ports:
- clk  in  1  125 MHz receive clock.
- rst  in  1  asynchronous, active-high reset.
- gmii_rx_dv  in  1  GMII data valid.
- gmii_rx_er  in  1  GMII receive error.
- gmii_rxd  in  8  GMII receive data.
- rx_en  out  1  body byte valid; contiguous for the whole body.
- rx_data  out  8  body byte.
- frame_done  out  1  one-cycle end-of-frame pulse.
- frame_good  out  1  frame status; valid only while frame_done is high.
- frame_len  out  16  body bytes emitted (count of rx_en cycles); valid with frame_done.
- drop_count  out  32  saturating count of bad or aborted frames.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, FCS delay line cleared. Reset is asynchronous and active-high; it acts immediately, including mid-frame.
- Input register: gmii_* are registered once. All decisions below use the registered values.
- FSM states: IDLE=0, PREAMBLE=1, BODY=2, DROP=3.
  - IDLE:
    - dv=1 and rxd=0x55 -> PREAMBLE, with pcnt=1.
    - dv=1 and any other rxd -> DROP, silently; drop_count is not incremented.
  - PREAMBLE:
    - 0x55 -> pcnt++, saturating at 7.
    - 0xD5 with pcnt>=MIN_PREAMBLE -> BODY; byte counter and CRC are initialised.
    - Any other byte, or 0xD5 too early -> DROP, drop_count++.
    - dv=0 -> IDLE, drop_count++.
  - BODY: each dv=1 byte shifts into a 4-byte delay line and increments the body byte counter.
  - DROP: stays in DROP while dv=1; dv=0 -> IDLE. No output is produced.
- FCS stripping / latency:
  - Body byte k drives rx_data with rx_en=1 exactly 2 clk edges after body byte k+4 is on gmii_rxd.
  - So the last 4 bytes (the FCS) are never emitted.
  - Bodies shorter than 5 bytes emit nothing.
- End of frame: dv falls while in BODY.
  - frame_done pulses on the cycle after the last rx_en cycle, or 2 edges after dv falls if nothing was emitted.
  - frame_len = bytes emitted.
  - FSM -> IDLE.
- frame_good = 1 only if all of the following hold:
  - frame_len>=MIN_LEN;
  - no rx_er was seen during BODY;
  - no abort occurred;
  - the CRC check passes (only when the optional feature is enabled).
- rx_er during BODY: the error is latched and bytes continue to pass through unchanged.
- Oversize: when the received byte count reaches MAX_FRAME+1, the current and all later output bytes are suppressed.
  - rx_en falls after exactly MAX_FRAME-4 emitted bytes.
  - frame_done pulses with good=0 in the next cycle.
  - FSM -> DROP.
- drop_count: increments on every frame_done with good=0, and on every preamble abort. It saturates at 0xFFFFFFFF.
- Inter-frame gap: at least one dv=0 cycle between frames is required. Back-to-back frames with a 1-cycle gap must both be framed correctly.
- Reset mid-frame: if dv is still high after reset releases, the remaining bytes go IDLE->DROP. No rx_en and no frame_done are produced.

Optional Feature:
- Macro: GMII_RX_FCS_CHECK_EN.
- Defined:
  - CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF) is run over all body bytes including the FCS.
  - The CRC check passes if the register equals the residue 0xDEBB20E3 at end of frame.
  - A mismatch forces frame_good=0.
- Undefined: no CRC logic is built and the CRC term is treated as pass. Latency and all other behaviour are identical.

Decomposition:
- Package eth_rx_pkg holds:
  - state encodings: IDLE, PREAMBLE, BODY, DROP;
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5;
  - CRC32_POLY and CRC32_RESIDUE;
  - the frame_len width constant.
- One sub-module: crc32_d8, a combinational next-CRC function taking 8 data bits and the 32-bit current CRC. It is instantiated only under GMII_RX_FCS_CHECK_EN.

Test Plan:
- Good frame: 7x0x55, 0xD5, 60-byte body + valid FCS (64 bytes).
  - Expect 60 contiguous rx_en cycles, with first rx_data 2 edges after body byte 4 is on gmii_rxd.
  - Expect frame_done with frame_len=60, frame_good=1, drop_count unchanged.
- Same frame with body byte 10 flipped (macro defined) -> same 60 rx_en cycles, frame_good=0, drop_count=1.
- Preamble 0x55 0x55 0x44 then 20 bytes -> no rx_en, no frame_done, drop_count+1.
- Short frame: 12-byte body + FCS -> 12 rx_en cycles, frame_len=12, frame_good=0.
- 1600-byte body -> exactly 1514 rx_en cycles, frame_done with len=1514 and good=0, then DROP until dv falls. The next good frame after a 1-cycle gap must be accepted.
- rx_er pulsed mid-body -> bytes unchanged, frame_good=0. Separately, rst mid-body -> outputs 0 at once, rest of frame ignored, drop_count=0.
